// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: glyph, anode and decode constants plus FSM states for the scan capture
package seg_scan_pkg;
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [3:0] AN_LEFT     = 4'b0111;
    localparam logic [3:0] AN_MIDLEFT  = 4'b1011;
    localparam logic [3:0] AN_MIDRIGHT = 4'b1101;
    localparam logic [3:0] AN_RIGHT    = 4'b1110;
    localparam logic [3:0] AN_IDLE     = 4'b1111;
    localparam logic [3:0] DIG_BLANK   = 4'hF;
    localparam logic [3:0] DIG_BAD     = 4'hE;
    typedef enum logic [1:0] {EXP_LEFT, EXP_MIDLEFT, EXP_MIDRIGHT, EXP_RIGHT} state_e;
endpackage

// File: rtl/seg_scan_capture_decode.sv
// seg_glyph_decode: active-low seven-segment glyph back to a 4-bit digit
module seg_glyph_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o
);
    always_comb begin
        case (seg_i)
            GLYPH_0:     digit_o = 4'd0;
            GLYPH_1:     digit_o = 4'd1;
            GLYPH_2:     digit_o = 4'd2;
            GLYPH_3:     digit_o = 4'd3;
            GLYPH_4:     digit_o = 4'd4;
            GLYPH_5:     digit_o = 4'd5;
            GLYPH_6:     digit_o = 4'd6;
            GLYPH_7:     digit_o = 4'd7;
            GLYPH_8:     digit_o = 4'd8;
            GLYPH_9:     digit_o = 4'd9;
            GLYPH_BLANK: digit_o = DIG_BLANK;
            default:     digit_o = DIG_BAD;
        endcase
    end
endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples the multiplexed an/seg bus and rebuilds left-to-right digit frames
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       sclk,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    output logic [3:0] dleft,
    output logic [3:0] dmidleft,
    output logic [3:0] dmidright,
    output logic [3:0] dright,
    output logic       frame_done,
    output logic       valid,
    output logic       seq_err,
    output logic       glyph_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e          state_q, state_d;
    logic [2:0][3:0] shadow_q, shadow_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d, frame_done_q, frame_done_d;
    logic            seq_err_q, seq_err_d, glyph_err_q, glyph_err_d;
    logic [3:0]      dec;
    logic [1:0]      slot, prev;
    logic            idle, one_hot, accept;

    seg_glyph_decode u_decode (.seg_i(seg), .digit_o(dec));

    assign idle    = an == AN_IDLE;
    assign one_hot = $countones(~an) == 1;
    assign slot    = !an[3] ? 2'd0 : !an[2] ? 2'd1 : !an[1] ? 2'd2 : 2'd3;
    // Slot accepted just before the expected one; only meaningful mid-frame.
    assign prev    = 2'(state_q) - 2'd1;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        dig_d        = dig_q;
        valid_d      = valid_q;
        frame_done_d = 1'b0;
        seq_err_d    = 1'b0;
        glyph_err_d  = 1'b0;
        accept       = 1'b0;
        cnt_d        = !idle ? '0 : cnt_q == CW'(TIMEOUT_CYCLES) ? cnt_q : cnt_q + 1'b1;
        if (idle) begin
            if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
                valid_d = 1'b0;
                state_d = EXP_LEFT;
            end
        end else if (!one_hot) begin
            seq_err_d = 1'b1;
            state_d   = EXP_LEFT;
        end else if (slot == 2'(state_q)) begin
            accept  = 1'b1;
            state_d = state_e'(2'(state_q) + 2'd1);
            if (state_q == EXP_RIGHT) begin
                dig_d        = {dec, shadow_q};
                frame_done_d = 1'b1;
                valid_d      = 1'b1;
            end
        end else if (state_q != EXP_LEFT && slot == prev) begin
            accept = 1'b1;
        end else if (state_q != EXP_LEFT) begin
            seq_err_d = 1'b1;
            accept    = slot == 2'd0;
            state_d   = slot == 2'd0 ? EXP_MIDLEFT : EXP_LEFT;
        end
        for (int i = 0; i < 3; i++)
            if (accept && slot == 2'(i)) shadow_d[i] = dec;
        glyph_err_d = accept && dec == DIG_BAD;
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q      <= EXP_LEFT;
            shadow_q     <= {3{DIG_BLANK}};
            dig_q        <= {4{DIG_BLANK}};
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
            glyph_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            dig_q        <= dig_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            seq_err_q    <= seq_err_d;
            glyph_err_q  <= glyph_err_d;
        end
    end

    assign dleft      = dig_q[0];
    assign dmidleft   = dig_q[1];
    assign dmidright  = dig_q[2];
    assign dright     = dig_q[3];
    assign frame_done = frame_done_q;
    assign valid      = valid_q;
    assign seq_err    = seq_err_q;
    assign glyph_err  = glyph_err_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed and random scan traffic checked against a frame-level reference model
module tb_seg_scan_capture;
    logic       sclk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg = 7'h7F;
    logic [3:0] an = 4'hF;
    logic [3:0] dleft, dmidleft, dmidright, dright;
    logic       frame_done, valid, seq_err, glyph_err;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_fd = 0;
    logic [6:0] gly [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [3:0] anc [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    seg_scan_capture dut (
        .sclk(sclk), .reset(reset), .seg(seg), .an(an),
        .dleft(dleft), .dmidleft(dmidleft), .dmidright(dmidright), .dright(dright),
        .frame_done(frame_done), .valid(valid), .seq_err(seq_err), .glyph_err(glyph_err)
    );

    always #5 sclk = ~sclk;

    int         nacc, icnt;
    logic [3:0] part [4];
    logic [3:0] mdig [4];
    logic       m_fd, m_val, m_seq, m_gly;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] dec(input logic [6:0] s);
        if (s == 7'h7F) return 4'hF;
        for (int i = 0; i < 10; i++) if (s == gly[i]) return 4'(i);
        return 4'hE;
    endfunction

    task automatic model_reset();
        nacc = 0; icnt = 0;
        m_fd = 0; m_val = 0; m_seq = 0; m_gly = 0;
        for (int i = 0; i < 4; i++) begin part[i] = 4'hF; mdig[i] = 4'hF; end
    endtask

    // Frame-level view: nacc digits of a left-to-right frame collected so far.
    task automatic model_step(input logic [3:0] a, input logic [6:0] s);
        int p;
        logic [3:0] d;
        d = dec(s);
        m_fd = 0; m_seq = 0; m_gly = 0;
        p = -1;
        for (int i = 0; i < 4; i++) if (a == anc[i]) p = i;
        if (a == 4'hF) begin
            if (icnt < 16) icnt++;
            if (icnt == 16) begin m_val = 0; nacc = 0; end
        end else begin
            icnt = 0;
            if (p < 0) begin
                m_seq = 1; nacc = 0;
            end else if (p == nacc) begin
                part[p] = d; m_gly = d == 4'hE;
                if (p == 3) begin
                    mdig = part; m_fd = 1; m_val = 1; nacc = 0;
                end else nacc++;
            end else if (nacc > 0 && p == nacc - 1) begin
                part[p] = d; m_gly = d == 4'hE;
            end else if (nacc > 0) begin
                m_seq = 1; nacc = 0;
                if (p == 0) begin part[0] = d; m_gly = d == 4'hE; nacc = 1; end
            end
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s);
        an = a; seg = s;
        @(posedge sclk);
        model_step(a, s);
        cyc++;
        #1;
        if (frame_done) last_fd = cyc;
        check("digits", {dleft, dmidleft, dmidright, dright}, {mdig[0], mdig[1], mdig[2], mdig[3]});
        check("frame_done", 16'(frame_done), 16'(m_fd));
        check("valid", 16'(valid), 16'(m_val));
        check("seq_err", 16'(seq_err), 16'(m_seq));
        check("glyph_err", 16'(glyph_err), 16'(m_gly));
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
        step(anc[0], s0); step(anc[1], s1); step(anc[2], s2); step(anc[3], s3);
    endtask

    initial begin
        int fd_a;
        int ptr;
        model_reset();
        #12;
        check("rst_digits", {dleft, dmidleft, dmidright, dright}, 16'hFFFF);
        check("rst_flags", {12'h0, frame_done, valid, seq_err, glyph_err}, 16'h0);
        @(negedge sclk) reset = 1'b0;

        frame(gly[0], gly[1], gly[2], gly[3]);
        check("f1_digits", {dleft, dmidleft, dmidright, dright}, 16'h0123);
        check("f1_valid", {15'h0, valid}, 16'h1);
        fd_a = last_fd;
        frame(gly[9], gly[8], gly[7], gly[6]);
        check("b2b_gap", 16'(last_fd - fd_a), 16'd4);
        check("f2_digits", {dleft, dmidleft, dmidright, dright}, 16'h9876);

        step(anc[0], gly[1]); step(anc[2], gly[2]);
        check("seq_pulse", {15'h0, seq_err}, 16'h1);
        check("seq_hold", {dleft, dmidleft, dmidright, dright}, 16'h9876);

        repeat (15) step(4'hF, 7'h7F);
        check("idle15_valid", {15'h0, valid}, 16'h1);
        step(4'hF, 7'h7F);
        check("idle16_valid", {15'h0, valid}, 16'h0);
        check("idle_hold", {dleft, dmidleft, dmidright, dright}, 16'h9876);
        frame(gly[4], gly[5], gly[6], gly[7]);
        check("revalid", {15'h0, valid}, 16'h1);

        step(anc[0], gly[1]); step(anc[1], 7'b0101010);
        check("glyph_pulse", {15'h0, glyph_err}, 16'h1);
        step(anc[2], gly[2]); step(anc[3], gly[3]);
        check("glyph_dig", {12'h0, dmidleft}, 16'hE);
        frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        check("blank_frame", {dleft, dmidleft, dmidright, dright}, 16'hFFFF);

        step(anc[0], gly[5]); step(anc[1], gly[6]);
        #2 reset = 1'b1;
        #1 model_reset();
        check("midrst_digits", {dleft, dmidleft, dmidright, dright}, 16'hFFFF);
        check("midrst_valid", {15'h0, valid}, 16'h0);
        @(negedge sclk) reset = 1'b0;
        step(anc[2], gly[2]); step(anc[3], gly[3]);
        check("hunt_nodone", {15'h0, frame_done}, 16'h0);
        frame(gly[3], gly[1], gly[4], gly[1]);
        check("post_rst", {dleft, dmidleft, dmidright, dright}, 16'h3141);

        ptr = 0;
        repeat (1500) begin
            int r, k;
            logic [6:0] s;
            r = $urandom_range(99);
            k = $urandom_range(99);
            s = k < 80 ? gly[$urandom_range(9)] : k < 90 ? 7'h7F : 7'($urandom);
            if (r < 60) begin
                step(anc[ptr], s);
                ptr = (ptr + 1) % 4;
            end else if (r < 68) begin
                repeat (int'($urandom_range(20, 1))) step(4'hF, s);
            end else begin
                step(4'($urandom), s);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
